mem_port_arbiter: RTL and testbench
===================================

// Module: mem_port_arbiter
// PURPOSE
//  Shares one single-port synchronous BRAM (1-cycle read latency) between the instruction-fetch
//  requester and the data (mem-stage) requester. Issues at most one access per cycle and routes
//  each read return to its owner. Drives the fetch stall line when a fetch request is not granted.
//  Sits between ifetch/mem stages and the unified memory macro.
// PARAMETERS
//  ADDR_W      14  word-address width (byte addr [ADDR_W+1:2])
//  DATA_W      32  data width; byte enables = DATA_W/8
//  STARVE_MAX  4   consecutive data grants while fetch waits before fetch is forced (>=1)
// PORTS
//  sys_clk    in   1         clock; all state on posedge
//  rst        in   1         synchronous, active-high reset
//  if_req     in   1         fetch read request (held until if_gnt)
//  if_addr    in   ADDR_W    fetch word address
//  if_gnt     out  1         fetch accepted this cycle (combinational)
//  if_rvalid  out  1         fetch data valid (cycle after if_gnt)
//  if_rdata   out  DATA_W    fetch data
//  d_req      in   1         data request (held until d_gnt)
//  d_we       in   1         1 = write, 0 = read
//  d_be       in   DATA_W/8  write byte enables
//  d_addr     in   ADDR_W    data word address
//  d_wdata    in   DATA_W    write data
//  d_gnt      out  1         data accepted this cycle (combinational)
//  d_rvalid   out  1         data read valid (cycle after read grant; never for writes)
//  d_rdata    out  DATA_W    data read value
//  mem_en     out  1         memory enable
//  mem_we     out  DATA_W/8  memory byte write enables
//  mem_addr   out  ADDR_W    memory address
//  mem_wdata  out  DATA_W    memory write data
//  mem_rdata  in   DATA_W    memory read data (valid cycle after mem_en read)
//  stall_out  out  1         = if_req & ~if_gnt
// BEHAVIOUR
//  - Grant (comb.): only d_req -> data; only if_req -> fetch; both -> data, unless starve_cnt==STARVE_MAX -> fetch.
//  - mem_* driven combinationally from the granted requester; none granted -> mem_en=0, mem_we=0.
//  - mem_we = d_be when data write granted, else 0; d_we=1 with d_be=0 still granted, no byte written.
//  - Return FSM (registered): IDLE / RET_IF / RET_D. Next state = RET_IF on fetch grant,
//    RET_D on data read grant, IDLE otherwise (incl. data write). Pipelined: new grant allowed
//    in any state, so back-to-back returns occur every cycle.
//  - RET_IF: if_rvalid=1, if_rdata=mem_rdata. RET_D: d_rvalid=1, d_rdata=mem_rdata.
//    Non-valid rdata outputs are held at 0.
//  - starve_cnt (width clog2(STARVE_MAX+1)): +1 when data granted and if_req=1; cleared on fetch
//    grant or if_req=0; saturates at STARVE_MAX.
//  - Reset: state=IDLE, starve_cnt=0, all rvalid=0, rdata=0; a return in flight at reset is
//    dropped (no rvalid after rst). Grants are 0 while rst=1.
// CONFIGURATION
//  ARB_PERF_CNT_EN defined: adds ports perf_if_stall (out 32, cycles with stall_out=1) and
//    perf_conflict (out 32, cycles with if_req&d_req); both wrap at 2^32, cleared by rst.
//  Undefined: ports and counters absent; behaviour otherwise identical.
// STRUCTURE
//  - Package mem_arb_pkg: return-state encoding (IDLE=2'd0, RET_IF=2'd1, RET_D=2'd2), owner
//    localparams, default STARVE_MAX.
//  - One sub-module, mem_arb_perf (counters), instantiated only under ARB_PERF_CNT_EN.
// TESTING
//  - if_req only, addr 0..3 back-to-back -> if_gnt every cycle, if_rvalid 1 cycle later, data=mem[0..3].
//  - d_req read addr 5 with if_req held -> d_gnt, stall_out=1, d_rvalid next cycle, if_rvalid=0.
//  - d_req held 6 cycles with if_req, STARVE_MAX=4 -> 4 data grants, 5th cycle fetch, then data.
//  - data write d_be=4'b0011 wdata=32'hAABBCCDD to addr 2 -> only low 2 bytes change; no d_rvalid.
//  - rst asserted the cycle after a fetch grant -> no if_rvalid; starve_cnt=0; outputs 0.
//  - ARB_PERF_CNT_EN: 3 conflict cycles -> perf_conflict=3, perf_if_stall=3.

Source files
------------

// File: rtl/mem_arb_pkg.sv
// Shared encodings for the fetch/data memory port arbiter.
// Return-state encoding, owner codes and the default starvation bound.
package mem_arb_pkg;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    RET_IF = 2'd1,
    RET_D  = 2'd2
  } ret_state_e;

  localparam logic [1:0] OWN_NONE = 2'd0;
  localparam logic [1:0] OWN_IF   = 2'd1;
  localparam logic [1:0] OWN_D    = 2'd2;

  localparam int STARVE_MAX_DEF = 4;

endpackage

// File: rtl/mem_port_arbiter_if.sv
// Fetch, data and memory-macro signals of the shared BRAM port.
// slave = arbiter side, master = requesters plus memory macro.
interface mem_port_arbiter_if #(
  parameter int ADDR_W = 14,
  parameter int DATA_W = 32
) ();

  logic              if_req;
  logic [ADDR_W-1:0] if_addr;
  logic              if_gnt;
  logic              if_rvalid;
  logic [DATA_W-1:0] if_rdata;

  logic                d_req;
  logic                d_we;
  logic [DATA_W/8-1:0] d_be;
  logic [ADDR_W-1:0]   d_addr;
  logic [DATA_W-1:0]   d_wdata;
  logic                d_gnt;
  logic                d_rvalid;
  logic [DATA_W-1:0]   d_rdata;

  logic                mem_en;
  logic [DATA_W/8-1:0] mem_we;
  logic [ADDR_W-1:0]   mem_addr;
  logic [DATA_W-1:0]   mem_wdata;
  logic [DATA_W-1:0]   mem_rdata;

  logic stall_out;

  modport slave (
    input  if_req, if_addr,
    output if_gnt, if_rvalid, if_rdata,
    input  d_req, d_we, d_be, d_addr, d_wdata,
    output d_gnt, d_rvalid, d_rdata,
    output mem_en, mem_we, mem_addr, mem_wdata,
    input  mem_rdata,
    output stall_out
  );

  modport master (
    output if_req, if_addr,
    input  if_gnt, if_rvalid, if_rdata,
    output d_req, d_we, d_be, d_addr, d_wdata,
    input  d_gnt, d_rvalid, d_rdata,
    input  mem_en, mem_we, mem_addr, mem_wdata,
    output mem_rdata,
    input  stall_out
  );

endinterface

// File: rtl/mem_arb_perf.sv
// Stall/conflict cycle counters, built only with ARB_PERF_CNT_EN.
// Both counters wrap at 2^32 and clear on rst.
`ifdef ARB_PERF_CNT_EN
module mem_arb_perf (
  input  logic        clk,
  input  logic        rst,
  input  logic        stall,
  input  logic        conflict,
  output logic [31:0] if_stall_cnt,
  output logic [31:0] conflict_cnt
);

  always_ff @(posedge clk) begin
    if (rst) begin
      if_stall_cnt <= '0;
      conflict_cnt <= '0;
    end else begin
      if_stall_cnt <= if_stall_cnt + 32'(stall);
      conflict_cnt <= conflict_cnt + 32'(conflict);
    end
  end

endmodule
`endif

// File: rtl/mem_port_arbiter.sv
// Fetch/data arbiter for one single-port 1-cycle BRAM.
// ARB_PERF_CNT_EN adds perf_if_stall / perf_conflict counters.
module mem_port_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W     = 14,
  parameter int DATA_W     = 32,
  parameter int STARVE_MAX = STARVE_MAX_DEF
) (
  input  logic sys_clk,
  input  logic rst,
  mem_port_arbiter_if.slave bus
`ifdef ARB_PERF_CNT_EN
  ,
  output logic [31:0] perf_if_stall,
  output logic [31:0] perf_conflict
`endif
);

  localparam int CW = $clog2(STARVE_MAX + 1);

  ret_state_e        state;
  logic [CW-1:0]     starve_cnt;
  logic              force_if;
  logic              gnt_if;
  logic              gnt_d;
  logic              rd_gnt;
  logic              if_rv;
  logic              d_rv;
  logic              stall;
  logic [1:0]        owner;
  logic [ADDR_W-1:0] addr_mux;
  logic [DATA_W-1:0] ret_data;

  assign force_if = starve_cnt == CW'(STARVE_MAX);
  assign gnt_if   = ~rst & bus.if_req & (~bus.d_req | force_if);
  assign gnt_d    = ~rst & bus.d_req & ~gnt_if;
  assign rd_gnt   = gnt_d & ~bus.d_we;
  assign stall    = bus.if_req & ~gnt_if;

  assign owner = gnt_d  ? OWN_D  :
                 gnt_if ? OWN_IF : OWN_NONE;

  assign bus.if_gnt    = gnt_if;
  assign bus.d_gnt     = gnt_d;
  assign bus.stall_out = stall;

  always_comb begin
    bus.mem_en    = 1'b0;
    bus.mem_we    = '0;
    bus.mem_wdata = '0;
    addr_mux      = '0;
    unique case (owner)
      OWN_IF: begin
        bus.mem_en = 1'b1;
        addr_mux   = bus.if_addr;
      end
      OWN_D: begin
        bus.mem_en    = 1'b1;
        bus.mem_we    = bus.d_we ? bus.d_be : '0;
        bus.mem_wdata = bus.d_wdata;
        addr_mux      = bus.d_addr;
      end
      default: ;
    endcase
  end

  assign bus.mem_addr = addr_mux;

  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state <= IDLE;
      if_rv <= 1'b0;
      d_rv  <= 1'b0;
    end else begin
      if_rv <= gnt_if;
      d_rv  <= rd_gnt;
      unique case (1'b1)
        gnt_if:  state <= RET_IF;
        rd_gnt:  state <= RET_D;
        default: state <= IDLE;
      endcase
    end
  end

  // Forced fetch only fires after STARVE_MAX data wins, so no wrap past it.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      starve_cnt <= '0;
    end else if (!bus.if_req || gnt_if) begin
      starve_cnt <= '0;
    end else if (gnt_d && !force_if) begin
      starve_cnt <= starve_cnt + 1'b1;
    end
  end

  // Gating with rst drops a return that was in flight when reset hit.
  assign ret_data      = bus.mem_rdata;
  assign bus.if_rvalid = if_rv & ~rst;
  assign bus.d_rvalid  = d_rv & ~rst;
  assign bus.if_rdata  = (state == RET_IF && !rst) ? ret_data : '0;
  assign bus.d_rdata   = (state == RET_D && !rst) ? ret_data : '0;

`ifdef ARB_PERF_CNT_EN
  mem_arb_perf u_perf (
    .clk          (sys_clk),
    .rst          (rst),
    .stall        (stall),
    .conflict     (bus.if_req & bus.d_req),
    .if_stall_cnt (perf_if_stall),
    .conflict_cnt (perf_conflict)
  );
`endif

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a return scoreboard.
// Set ARB_PERF_CNT_EN to also exercise the perf counters.
module tb_mem_port_arbiter;

  logic sys_clk = 1'b0;
  logic rst;
  logic mem_load;

  always #5 sys_clk = ~sys_clk;

  mem_port_arbiter_if #(.ADDR_W(14), .DATA_W(32)) bus ();

`ifdef ARB_PERF_CNT_EN
  logic [31:0] perf_if_stall;
  logic [31:0] perf_conflict;
`endif

  mem_port_arbiter #(
    .ADDR_W     (14),
    .DATA_W     (32),
    .STARVE_MAX (4)
  ) dut (
    .sys_clk (sys_clk),
    .rst     (rst),
    .bus     (bus)
`ifdef ARB_PERF_CNT_EN
    ,
    .perf_if_stall (perf_if_stall),
    .perf_conflict (perf_conflict)
`endif
  );

  typedef struct packed {
    logic        is_d;
    logic [31:0] data;
  } exp_t;

  exp_t        q[$];
  logic [31:0] tb_mem [16];
  logic [31:0] ref_mem [16];
  int          passed = 0;
  int          total  = 0;

  function automatic logic [31:0] init_word(input int i);
    return 32'h5A00_0000 ^ (32'(i) * 32'h0001_0203);
  endfunction

  always @(posedge sys_clk) begin
    if (mem_load) begin
      for (int i = 0; i < 16; i++) tb_mem[i] <= init_word(i);
    end else if (bus.mem_en) begin
      for (int b = 0; b < 4; b++)
        if (bus.mem_we[b])
          tb_mem[bus.mem_addr[3:0]][8*b +: 8] <= bus.mem_wdata[8*b +: 8];
      bus.mem_rdata <= tb_mem[bus.mem_addr[3:0]];
    end
  end

  task automatic check(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic set_in(input bit r, input bit ir, input logic [13:0] ia,
                        input bit dr, input bit dwe, input logic [3:0] be,
                        input logic [13:0] da, input logic [31:0] wd);
    rst         = r;
    bus.if_req  = ir;
    bus.if_addr = ia;
    bus.d_req   = dr;
    bus.d_we    = dwe;
    bus.d_be    = be;
    bus.d_addr  = da;
    bus.d_wdata = wd;
  endtask

  task automatic check_ret(input string tag);
    exp_t        e;
    bit          have;
    logic [31:0] xi;
    logic [31:0] xd;
    have = q.size() > 0;
    e    = '0;
    if (have) e = q.pop_front();
    xi = (have && !e.is_d) ? e.data : 32'h0;
    xd = (have && e.is_d) ? e.data : 32'h0;
    check({tag, "_if_rvalid"}, 32'(bus.if_rvalid), 32'(have && !e.is_d));
    check({tag, "_d_rvalid"}, 32'(bus.d_rvalid), 32'(have && e.is_d));
    check({tag, "_if_rdata"}, bus.if_rdata, xi);
    check({tag, "_d_rdata"}, bus.d_rdata, xd);
  endtask

  task automatic run(input string tag, input bit eig, input bit edg);
    logic [3:0] a;
    #1;
    if (rst) q.delete();
    check_ret(tag);
    check({tag, "_if_gnt"}, 32'(bus.if_gnt), 32'(eig));
    check({tag, "_d_gnt"}, 32'(bus.d_gnt), 32'(edg));
    check({tag, "_stall"}, 32'(bus.stall_out), 32'(bus.if_req & ~eig));
    check({tag, "_mem_en"}, 32'(bus.mem_en), 32'(eig | edg));
    if (eig) begin
      a = bus.if_addr[3:0];
      check({tag, "_addr"}, 32'(bus.mem_addr), 32'(bus.if_addr));
      q.push_back('{1'b0, ref_mem[a]});
    end
    if (edg) begin
      a = bus.d_addr[3:0];
      check({tag, "_addr"}, 32'(bus.mem_addr), 32'(bus.d_addr));
      check({tag, "_we"}, 32'(bus.mem_we), bus.d_we ? 32'(bus.d_be) : 32'h0);
      if (!bus.d_we) begin
        q.push_back('{1'b1, ref_mem[a]});
      end else begin
        for (int b = 0; b < 4; b++)
          if (bus.d_be[b]) ref_mem[a][8*b +: 8] = bus.d_wdata[8*b +: 8];
      end
    end
    if (!eig && !edg) check({tag, "_we0"}, 32'(bus.mem_we), 32'h0);
    @(posedge sys_clk);
    #1;
  endtask

  initial begin
    for (int i = 0; i < 16; i++) ref_mem[i] = init_word(i);
    mem_load = 1'b1;
    bus.mem_rdata = '0;
    set_in(1, 0, 0, 0, 0, 0, 0, 0);
    @(posedge sys_clk);
    #1;
    run("rst_idle", 0, 0);
    set_in(1, 1, 0, 1, 0, 0, 1, 0);
    run("rst_gnt", 0, 0);
    mem_load = 1'b0;

    for (int i = 1; i <= 3; i++) begin
      set_in(0, 1, 0, 1, 0, 0, 14'(i), 0);
      run($sformatf("conf%0d", i), 0, 1);
    end
    set_in(0, 1, 0, 0, 0, 0, 0, 0);
    run("conf_if", 1, 0);
`ifdef ARB_PERF_CNT_EN
    check("perf_conflict", perf_conflict, 32'd3);
    check("perf_if_stall", perf_if_stall, 32'd3);
`endif

    for (int i = 0; i < 4; i++) begin
      set_in(0, 1, 14'(i), 0, 0, 0, 0, 0);
      run($sformatf("fetch%0d", i), 1, 0);
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    run("fetch_drain", 0, 0);

    set_in(0, 1, 4, 1, 0, 0, 5, 0);
    run("drd5", 0, 1);
    set_in(0, 1, 4, 0, 0, 0, 0, 0);
    run("drd5_ret", 1, 0);
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    run("drd5_drain", 0, 0);

    for (int i = 0; i < 6; i++) begin
      set_in(0, 1, 7, 1, 0, 0, 14'(6 + i), 0);
      run($sformatf("starve%0d", i), i == 4, i != 4);
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    run("starve_drain", 0, 0);

    set_in(0, 0, 0, 1, 1, 4'b0011, 2, 32'hAABB_CCDD);
    run("wr2", 0, 1);
    set_in(0, 0, 0, 1, 0, 0, 2, 0);
    run("rd2", 0, 1);
    check("wr2_ref", ref_mem[2], {init_word(2)[31:16], 16'hCCDD});
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    run("rd2_drain", 0, 0);

    set_in(0, 1, 3, 0, 0, 0, 0, 0);
    run("pre_rst_if", 1, 0);
    set_in(1, 1, 3, 1, 0, 0, 4, 0);
    run("rst_drop", 0, 0);
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    run("post_rst", 0, 0);

    for (int i = 0; i < 2; i++) begin
      set_in(0, 1, 9, 1, 0, 0, 14'(10 + i), 0);
      run($sformatf("pre_cnt%0d", i), 0, 1);
    end
    set_in(1, 1, 9, 1, 0, 0, 12, 0);
    run("cnt_rst", 0, 0);
    for (int i = 0; i < 5; i++) begin
      set_in(0, 1, 9, 1, 0, 0, 14'(i), 0);
      run($sformatf("cnt_clr%0d", i), i == 4, i != 4);
    end
    set_in(0, 0, 0, 0, 0, 0, 0, 0);
    run("final_drain", 0, 0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
